// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer that borrows the shared ALU for every add and shift step.
// Latency: done rises 2k+1 cycles after accept (k = MSB index of b plus 1, or N without early exit).
// Backpressure: start is taken only while ready is high; start while busy is ignored.
module alu_mul_seq #(
  parameter int N          = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] product,
  output logic         ofl,
  output logic [N-1:0] alu_InA,
  output logic [N-1:0] alu_InB,
  output logic [2:0]   alu_Op,
  output logic         alu_Cin,
  output logic         alu_invA,
  output logic         alu_invB,
  output logic         alu_sign,
  input  logic [N-1:0] alu_Out,
  input  logic         alu_Ofl
);

  localparam int IW = $clog2(N) + 1;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [N-1:0]   acc;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [IW-1:0]  iter;
  // Overflow gathered during the run; only published to ofl alongside product.
  logic           ofl_run;

  logic [N-1:0]   mplier_sh;
  logic [IW-1:0]  iter_inc;
  logic           last_iter;
  logic           shift_loss;

  assign mplier_sh  = mplier >> 1;
  assign iter_inc   = iter + IW'(1);
  assign last_iter  = (iter_inc == IW'(N)) || ((EARLY_EXIT != 0) && (mplier_sh == '0));
  // The bit about to fall off mcand would still be needed by a later set multiplier bit.
  assign shift_loss = mcand[N-1] && (mplier_sh != '0);

  assign ready    = (state == S_IDLE) || (state == S_DONE);
  assign alu_Cin  = 1'b0;
  assign alu_invA = 1'b0;
  assign alu_invB = 1'b0;
  assign alu_sign = 1'b0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state selection.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_ADD;
      S_ADD:   state_n = S_SHIFT;
      S_SHIFT: state_n = last_iter ? S_DONE : S_ADD;
      S_DONE:  state_n = start ? S_ADD : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // ALU operand/opcode drive; idle states present a harmless 0+0.
  always_comb begin
    alu_InA = '0;
    alu_InB = '0;
    alu_Op  = OP_ADD;
    case (state)
      S_ADD: begin
        alu_InA = acc;
        alu_InB = mcand;
        alu_Op  = OP_ADD;
      end
      S_SHIFT: begin
        alu_InA = mcand;
        alu_InB = N'(1);
        alu_Op  = OP_SLL;
      end
      default: ;
    endcase
  end

  // Datapath: latch operands on accept, write back ALU results, publish product/ofl at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      iter    <= '0;
      ofl_run <= 1'b0;
      product <= '0;
      ofl     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state_n == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            iter    <= '0;
            ofl_run <= 1'b0;
          end
        end
        S_ADD: begin
          if (mplier[0]) begin
            acc     <= alu_Out;
            ofl_run <= ofl_run | alu_Ofl;
          end
        end
        S_SHIFT: begin
          mcand  <= alu_Out;
          mplier <= mplier_sh;
          iter   <= iter_inc;
          if (shift_loss) ofl_run <= 1'b1;
          if (last_iter) begin
            product <= acc;
            ofl     <= ofl_run | shift_loss;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two instances (early exit on/off), each wired to a behavioural ALU.
// A transaction-level model predicts ready/done/product/ofl from a*b and the bit length of b.
// Directed cases pin the model with literal values, then random vectors run against it.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        st      [2];

  logic        d_ready [2];
  logic        d_done  [2];
  logic        d_ofl   [2];
  logic [15:0] d_prod  [2];
  logic [15:0] d_ina   [2];
  logic [15:0] d_inb   [2];
  logic [2:0]  d_op    [2];
  logic        d_cin   [2];
  logic        d_inva  [2];
  logic        d_invb  [2];
  logic        d_sign  [2];
  logic [16:0] alu_r   [2];

  int total = 0;
  int bad   = 0;

  // Behavioural 16-bit ALU: ADD returns carry in bit 16, SLL shifts by InB[3:0].
  function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      3'b100:  return {1'b0, x} + {1'b0, y};
      3'b001:  return {1'b0, x << y[3:0]};
      default: return 17'h0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) alu_r[i] = alu_f(d_op[i], d_ina[i], d_inb[i]);
  end

  alu_mul_seq #(.N(16), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst(rst), .start(st[0]), .a(a), .b(b),
    .ready(d_ready[0]), .done(d_done[0]), .product(d_prod[0]), .ofl(d_ofl[0]),
    .alu_InA(d_ina[0]), .alu_InB(d_inb[0]), .alu_Op(d_op[0]), .alu_Cin(d_cin[0]),
    .alu_invA(d_inva[0]), .alu_invB(d_invb[0]), .alu_sign(d_sign[0]),
    .alu_Out(alu_r[0][15:0]), .alu_Ofl(alu_r[0][16])
  );

  alu_mul_seq #(.N(16), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst(rst), .start(st[1]), .a(a), .b(b),
    .ready(d_ready[1]), .done(d_done[1]), .product(d_prod[1]), .ofl(d_ofl[1]),
    .alu_InA(d_ina[1]), .alu_InB(d_inb[1]), .alu_Op(d_op[1]), .alu_Cin(d_cin[1]),
    .alu_invA(d_inva[1]), .alu_invB(d_invb[1]), .alu_sign(d_sign[1]),
    .alu_Out(alu_r[1][15:0]), .alu_Ofl(alu_r[1][16])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Number of iterations: bit length of b (at least 1), or 16 when every bit is always processed.
  function automatic int kof(input logic [15:0] mb, input bit early);
    int k;
    if (!early) return 16;
    k = 1;
    for (int i = 0; i < 16; i++) if (mb[i]) k = i + 1;
    return k;
  endfunction

  // Transaction model: busy for 2k cycles after accept, then one done cycle with a*b.
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_ofl  [2];
  logic [15:0] m_prod [2];
  logic [15:0] m_pa   [2];
  logic [15:0] m_pb   [2];
  int          m_left [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_ofl[i]  <= 1'b0;
        m_prod[i] <= 16'h0;
        m_pa[i]   <= 16'h0;
        m_pb[i]   <= 16'h0;
        m_left[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] full;
        full = {16'h0, m_pa[i]} * {16'h0, m_pb[i]};
        m_done[i] <= 1'b0;
        if (!m_busy[i] && st[i]) begin
          m_busy[i] <= 1'b1;
          m_pa[i]   <= a;
          m_pb[i]   <= b;
          m_left[i] <= 2 * kof(b, i == 0);
        end else if (m_busy[i]) begin
          if (m_left[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_prod[i] <= full[15:0];
            m_ofl[i]  <= (full > 32'h0000_FFFF);
          end else begin
            m_left[i] <= m_left[i] - 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready%0d", i), 32'(d_ready[i]), 32'(!m_busy[i]));
      chk($sformatf("done%0d", i), 32'(d_done[i]), 32'(m_done[i]));
      chk($sformatf("product%0d", i), 32'(d_prod[i]), 32'(m_prod[i]));
      chk($sformatf("alu_ties%0d", i), 32'({d_cin[i], d_inva[i], d_invb[i], d_sign[i]}), 32'h0);
      if (m_done[i]) chk($sformatf("ofl%0d", i), 32'(d_ofl[i]), 32'(m_ofl[i]));
    end
  end

  // Called at a negedge with the target ready; returns at the negedge of cycle 1.
  task automatic launch(input int inst, input logic [15:0] ta, input logic [15:0] tb);
    a = ta;
    b = tb;
    st[inst] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input bit mid, output int cyc, output int rlow);
    cyc  = 1;
    rlow = 0;
    while (!d_done[inst] && cyc < 80) begin
      if (!d_ready[inst]) rlow++;
      if (mid && cyc == 3) begin
        a = 16'h0009;
        b = 16'h0009;
        st[inst] = 1'b1;
      end
      if (mid && cyc == 4) st[inst] = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!d_done[inst]) chk("done_timeout", 32'(cyc), 32'hFFFF_FFFF);
  endtask

  task automatic run(input int inst, input logic [15:0] ta, input logic [15:0] tb, input bit mid,
                     input string nm, input int ecyc, input logic [15:0] eprod, input logic eofl);
    int cyc;
    int rlow;
    launch(inst, ta, tb);
    wait_done(inst, mid, cyc, rlow);
    chk({nm, "_cyc"}, 32'(cyc), 32'(ecyc));
    chk({nm, "_prod"}, 32'(d_prod[inst]), 32'(eprod));
    chk({nm, "_ofl"}, 32'(d_ofl[inst]), 32'(eofl));
  endtask

  initial begin
    int cyc;
    int rlow;
    int pulses;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] full;

    rst   = 1'b1;
    st[0] = 1'b0;
    st[1] = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(d_ready[0]), 32'h1);
    chk("rst_done", 32'(d_done[0]), 32'h0);
    chk("rst_prod", 32'(d_prod[0]), 32'h0);
    chk("rst_ofl", 32'(d_ofl[0]), 32'h0);
    #2 rst = 1'b0;
    @(negedge clk);

    // 3*5: k=3 -> done in cycle 7, ready low for cycles 1..6.
    launch(0, 16'd3, 16'd5);
    wait_done(0, 1'b0, cyc, rlow);
    chk("m35_cyc", 32'(cyc), 32'd7);
    chk("m35_rlow", 32'(rlow), 32'd6);
    chk("m35_prod", 32'(d_prod[0]), 32'd15);
    chk("m35_ofl", 32'(d_ofl[0]), 32'h0);

    run(0, 16'h1234, 16'h0000, 1'b0, "bzero", 3, 16'h0000, 1'b0);
    run(0, 16'hFFFF, 16'hFFFF, 1'b0, "ffff", 33, 16'h0001, 1'b1);
    run(0, 16'h8000, 16'h0002, 1'b0, "shloss", 5, 16'h0000, 1'b1);
    run(0, 16'h4000, 16'h0002, 1'b0, "noloss", 5, 16'h8000, 1'b0);
    run(0, 16'd3, 16'd5, 1'b1, "midstart", 7, 16'd15, 1'b0);
    // Launched straight from the done cycle of the previous op: back-to-back accept.
    run(0, 16'd7, 16'd6, 1'b0, "b2b", 7, 16'd42, 1'b0);

    // Reset mid-operation: result dropped, product cleared, no done pulse afterwards.
    launch(0, 16'd3, 16'd5);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(d_ready[0]), 32'h1);
    chk("midrst_prod", 32'(d_prod[0]), 32'h0);
    chk("midrst_done", 32'(d_done[0]), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (d_done[0]) pulses++;
    end
    chk("midrst_pulses", 32'(pulses), 32'h0);

    // Early exit disabled: always 16 iterations.
    run(1, 16'd2, 16'd1, 1'b0, "full21", 33, 16'd2, 1'b0);
    run(1, 16'h0100, 16'h0100, 1'b0, "full_ofl", 33, 16'h0000, 1'b1);

    for (int n = 0; n < 1020; n++) begin
      int inst;
      inst = (n < 1000) ? 0 : 1;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      launch(inst, ra, rb);
      wait_done(inst, 1'b0, cyc, rlow);
      full = {16'h0, ra} * {16'h0, rb};
      chk("rnd_prod", 32'(d_prod[inst]), 32'(full[15:0]));
      chk("rnd_ofl", 32'(d_ofl[inst]), 32'(full > 32'h0000_FFFF));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
